t_ff_bank: RTL and testbench

- Parametrised multi-channel toggle register bank; next generation of the single-bit T flip-flop.
- Each of WIDTH channels is a T-type bit with set/clear/toggle commands.
- Adds a shared programmable auto-toggle divider (blink generator), per-channel change pulses and per-channel saturating toggle counters with a read mux.
- Sits between control/status logic and LED/strobe/enable outputs.

---
 rtl/t_ff_bank.sv | 107 ++++++++++
 tb/tb_t_ff_bank.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/t_ff_bank.sv
// Multi-channel T-flop bank: set/clear/toggle per channel, shared blink divider, change pulses, saturating change counters.
// Latency: 1 cycle from din_t/op/tick to dout_q, dout_chg and the counters; cnt_dout is a combinational read of the counters.
// Backpressure: none; a command is accepted in every cycle op_valid is high, and din_t is sampled every cycle.
module t_ff_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8,
    parameter int DIV_W = 16,
    parameter int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] din_t,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] op_mask,
    input  logic [WIDTH-1:0] auto_mask,
    input  logic [DIV_W-1:0] auto_period,
    input  logic             cnt_clr,
    input  logic [SEL_W-1:0] cnt_sel,
    output logic [WIDTH-1:0] dout_q,
    output logic [WIDTH-1:0] dout_chg,
    output logic             tick,
    output logic [CNT_W-1:0] cnt_dout
);

    localparam logic [1:0] OP_TOGGLE = 2'd1;
    localparam logic [1:0] OP_SET    = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    logic [DIV_W-1:0]            div_cnt_q;
    logic [DIV_W-1:0]            div_cnt_d;
    logic                        tick_now;
    logic                        tick_q;

    logic [WIDTH-1:0]            set_m;
    logic [WIDTH-1:0]            clr_m;
    logic [WIDTH-1:0]            tgl_m;
    logic [WIDTH-1:0]            dout_d;
    logic [WIDTH-1:0]            chg_d;
    logic [WIDTH-1:0]            chg_q;

    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

    // Divider: ">=" compare so a period lowered below the running count fires on the next cycle.
    always_comb begin
        tick_now  = (auto_period != '0) && (div_cnt_q >= auto_period);
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if ((auto_period == '0) || tick_now) begin
            div_cnt_d = '0;
        end
    end

    // Channel next state: all toggle sources merge into one inversion, then set, then clear on top.
    always_comb begin
        set_m  = {WIDTH{op_valid && (op_code == OP_SET)}}   & op_mask;
        clr_m  = {WIDTH{op_valid && (op_code == OP_CLEAR)}} & op_mask;
        tgl_m  = din_t
               | ({WIDTH{op_valid && (op_code == OP_TOGGLE)}} & op_mask)
               | ({WIDTH{tick_now}} & auto_mask);
        dout_d = ((dout_q ^ tgl_m) | set_m) & ~clr_m;
        chg_d  = dout_d ^ dout_q;
    end

    // Change counters: clear wins over a same-cycle increment; increments stop at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (chg_d[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Counter read mux; selects past the last channel read as zero.
    always_comb begin
        cnt_dout = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(cnt_sel) == i) begin
                cnt_dout = cnt_q[i];
            end
        end
    end

    // State registers; reset drops everything at once, including the divider phase.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            dout_q    <= '0;
            chg_q     <= '0;
            cnt_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_now;
            dout_q    <= dout_d;
            chg_q     <= chg_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dout_chg = chg_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_t_ff_bank.sv
module tb_t_ff_bank;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  din_t;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [7:0]  op_mask;
    logic [7:0]  auto_mask;
    logic [15:0] auto_period;
    logic        cnt_clr;
    logic [3:0]  cnt_sel;
    logic [7:0]  dout_q;
    logic [7:0]  dout_chg;
    logic        tick;
    logic [3:0]  cnt_dout;

    int checks = 0;
    int errors = 0;

    t_ff_bank #(.WIDTH(8), .CNT_W(4), .DIV_W(16), .SEL_W(4)) dut (
        .clk(clk), .n_rst(n_rst), .din_t(din_t), .op_valid(op_valid),
        .op_code(op_code), .op_mask(op_mask), .auto_mask(auto_mask),
        .auto_period(auto_period), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel),
        .dout_q(dout_q), .dout_chg(dout_chg), .tick(tick), .cnt_dout(cnt_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic       vld;
        logic [1:0] code;
        logic [7:0] mask;
        logic       clr;
        logic [3:0] sel;
        logic [7:0] e_dout;
        logic [7:0] e_chg;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        din_t    = 8'h00;
        op_valid = 1'b0;
        op_code  = 2'd0;
        op_mask  = 8'h00;
        cnt_clr  = 1'b0;
    endtask

    task automatic cmd(input logic [1:0] code, input logic [7:0] mask);
        op_valid = 1'b1;
        op_code  = code;
        op_mask  = mask;
    endtask

    initial begin
        logic       exp_d7;
        logic       exp_tk;
        logic [3:0] exp_cnt;
        logic [7:0] exp_dout;

        // {din, vld, code, mask, clr, sel, dout, chg, cnt}
        tbl[0]  = '{8'h01, 1'b0, 2'd0, 8'h00, 1'b0, 4'd0, 8'h01, 8'h01, 4'd1};
        tbl[1]  = '{8'h01, 1'b0, 2'd0, 8'h00, 1'b0, 4'd0, 8'h00, 8'h01, 4'd2};
        tbl[2]  = '{8'h01, 1'b0, 2'd0, 8'h00, 1'b0, 4'd0, 8'h01, 8'h01, 4'd3};
        tbl[3]  = '{8'h00, 1'b1, 2'd3, 8'hFF, 1'b0, 4'd0, 8'h00, 8'h01, 4'd4};
        tbl[4]  = '{8'h00, 1'b1, 2'd1, 8'hFF, 1'b0, 4'd1, 8'hFF, 8'hFF, 4'd1};
        tbl[5]  = '{8'h0F, 1'b1, 2'd2, 8'h0F, 1'b0, 4'd0, 8'hFF, 8'h00, 4'd5};
        tbl[6]  = '{8'h00, 1'b1, 2'd3, 8'h03, 1'b0, 4'd1, 8'hFC, 8'h03, 4'd2};
        tbl[7]  = '{8'h00, 1'b1, 2'd0, 8'hFF, 1'b0, 4'd0, 8'hFC, 8'h00, 4'd6};
        tbl[8]  = '{8'h00, 1'b0, 2'd1, 8'hFF, 1'b0, 4'd2, 8'hFC, 8'h00, 4'd1};
        tbl[9]  = '{8'h10, 1'b1, 2'd2, 8'h10, 1'b0, 4'd4, 8'hFC, 8'h00, 4'd1};
        tbl[10] = '{8'h80, 1'b1, 2'd3, 8'h80, 1'b0, 4'd7, 8'h7C, 8'h80, 4'd2};
        tbl[11] = '{8'h01, 1'b0, 2'd0, 8'h00, 1'b1, 4'd0, 8'h7D, 8'h01, 4'd0};
        tbl[12] = '{8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 4'd9, 8'h7D, 8'h00, 4'd0};
        tbl[13] = '{8'h02, 1'b0, 2'd0, 8'h00, 1'b0, 4'd1, 8'h7F, 8'h02, 4'd1};

        // Reset: outputs stay zero even with toggle requests present.
        n_rst       = 1'b0;
        idle_inputs();
        auto_mask   = 8'h00;
        auto_period = 16'd0;
        cnt_sel     = 4'd0;
        din_t       = 8'hFF;
        step();
        step();
        chk("rst_dout", dout_q, 8'h00);
        chk("rst_chg", dout_chg, 8'h00);
        chk("rst_tick", tick, 1'b0);
        chk("rst_cnt", cnt_dout, 4'd0);
        din_t = 8'h00;
        @(negedge clk);
        n_rst = 1'b1;
        #1;

        // Table: basic toggle, command priority, NOP/invalid commands, counter clear, read mux.
        for (int i = 0; i < 14; i++) begin
            din_t    = tbl[i].din;
            op_valid = tbl[i].vld;
            op_code  = tbl[i].code;
            op_mask  = tbl[i].mask;
            cnt_clr  = tbl[i].clr;
            cnt_sel  = tbl[i].sel;
            step();
            chk($sformatf("v%0d_dout", i), dout_q, tbl[i].e_dout);
            chk($sformatf("v%0d_chg", i), dout_chg, tbl[i].e_chg);
            chk($sformatf("v%0d_cnt", i), cnt_dout, tbl[i].e_cnt);
            chk($sformatf("v%0d_tick", i), tick, 1'b0);
        end
        idle_inputs();

        // Saturation: channel 1 counter starts at 1 and must stop at 15.
        din_t   = 8'h02;
        cnt_sel = 4'd1;
        exp_cnt = 4'd1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
            exp_dout = (k % 2 == 1) ? 8'h7D : 8'h7F;
            chk($sformatf("sat%0d_cnt", k), cnt_dout, exp_cnt);
            chk($sformatf("sat%0d_dout", k), dout_q, exp_dout);
        end
        cnt_clr = 1'b1;
        step();
        chk("clr_cnt", cnt_dout, 4'd0);
        chk("clr_dout", dout_q, 8'h7D);
        chk("clr_chg", dout_chg, 8'h02);
        idle_inputs();
        cnt_sel = 4'd9;
        #1;
        chk("sel9_cnt", cnt_dout, 4'd0);
        cnt_sel = 4'd0;

        // Auto-toggle with period 3: tick every 4th cycle and bit 7 follows it.
        cmd(2'd3, 8'hFF);
        step();
        chk("auto_pre", dout_q, 8'h00);
        idle_inputs();
        auto_period = 16'd3;
        auto_mask   = 8'h80;
        exp_d7      = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            exp_tk = (k % 4 == 3);
            exp_d7 = exp_d7 ^ exp_tk;
            chk($sformatf("auto%0d_tick", k), tick, exp_tk);
            chk($sformatf("auto%0d_dout", k), dout_q, {exp_d7, 7'h00});
        end
        auto_period = 16'd0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("off%0d_tick", k), tick, 1'b0);
            chk($sformatf("off%0d_dout", k), dout_q, 8'h80);
        end

        // Period lowered from 10 to 2 while the divider sits at 7.
        auto_mask   = 8'h00;
        auto_period = 16'd10;
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("p10_%0d_tick", k), tick, 1'b0);
        end
        auto_period = 16'd2;
        step();
        chk("lower_tick", tick, 1'b1);
        step();
        chk("lower_wrap1", tick, 1'b0);
        step();
        chk("lower_wrap2", tick, 1'b0);
        step();
        chk("lower_next", tick, 1'b1);

        // Coincident din, TOGGLE command and auto tick on channel 2.
        cmd(2'd3, 8'hFF);
        cnt_clr   = 1'b1;
        auto_mask = 8'h04;
        cnt_sel   = 4'd2;
        step();
        chk("co_clr_dout", dout_q, 8'h00);
        chk("co_clr_cnt", cnt_dout, 4'd0);
        idle_inputs();
        step();
        chk("co_wait_tick", tick, 1'b0);
        chk("co_wait_dout", dout_q, 8'h00);
        din_t = 8'h04;
        cmd(2'd1, 8'h04);
        step();
        chk("co_tick", tick, 1'b1);
        chk("co_dout", dout_q, 8'h04);
        chk("co_chg", dout_chg, 8'h04);
        chk("co_cnt", cnt_dout, 4'd1);
        idle_inputs();
        auto_period = 16'd0;
        auto_mask   = 8'h00;
        cnt_sel     = 4'd0;

        // Async reset mid-run with dout_q at A5 and the divider running.
        cmd(2'd3, 8'hFF);
        cnt_clr = 1'b1;
        step();
        idle_inputs();
        cmd(2'd2, 8'hA5);
        step();
        chk("ar_set_dout", dout_q, 8'hA5);
        chk("ar_set_chg", dout_chg, 8'hA5);
        idle_inputs();
        auto_period = 16'd3;
        step();
        step();
        chk("ar_hold_dout", dout_q, 8'hA5);
        chk("ar_cnt0", cnt_dout, 4'd1);
        #3;
        n_rst = 1'b0;
        #2;
        chk("ar_dout", dout_q, 8'h00);
        chk("ar_chg", dout_chg, 8'h00);
        chk("ar_tick", tick, 1'b0);
        chk("ar_cnt", cnt_dout, 4'd0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("ar_div%0d_tick", k), tick, k == 3);
            chk($sformatf("ar_div%0d_dout", k), dout_q, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
